sram_arbiter: RTL

Two-port arbiter and access sequencer for one asynchronous 32-bit board SRAM (BaseRAM or ExtRAM), placed between the CPU core and the SRAM pins. It shares the SRAM between the instruction-fetch port (read only) and the memory-stage port (read/write with byte enables). It grants the SRAM to one port at a time and generates multi-cycle read and write strobe sequences. It returns a one-cycle acknowledge per completed access, which the core uses to release its stall.

---
 rtl/sram_arbiter_if.sv | 63 ++++++
 rtl/sram_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_if
//  Description : Bundles the fetch port, the memory-stage port and the SRAM
//                pin-side signals of the SRAM arbiter. The slave modport is
//                the arbiter's view; the master modport is the view of
//                whatever surrounds it (core plus board SRAM).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int ADDR_W = 20
);
    // Instruction-fetch port (read only)
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [31:0]       if_rdata_o;
    logic              if_ack_o;

    // Memory-stage port (read/write with byte enables)
    logic              mem_req_i;
    logic              mem_we_i;
    logic [3:0]        mem_be_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic [31:0]       mem_rdata_o;
    logic              mem_ack_o;

    // SRAM pin side
    logic [ADDR_W-1:0] sram_addr_o;
    logic [31:0]       sram_wdata_o;
    logic              sram_wdata_oe_o;
    logic [31:0]       sram_rdata_i;
    logic              sram_ce_n_o;
    logic              sram_oe_n_o;
    logic              sram_we_n_o;
    logic [3:0]        sram_be_n_o;

    // Status
    logic              busy_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ack_o,
        input  mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, mem_ack_o,
        output sram_addr_o, sram_wdata_o, sram_wdata_oe_o,
        input  sram_rdata_i,
        output sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o,
        output busy_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ack_o,
        output mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, mem_ack_o,
        input  sram_addr_o, sram_wdata_o, sram_wdata_oe_o,
        output sram_rdata_i,
        input  sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o,
        input  busy_o
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Two-port arbiter and access sequencer for one asynchronous
//                32-bit SRAM. Grants the SRAM to the fetch port or the
//                memory-stage port, sequences multi-cycle read/write strobes
//                and returns a one-cycle acknowledge per completed access.
//                Every output comes straight from a register.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    sram_arbiter_if.slave   bus
);

    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    // Port encoding for the grant and last-grant flags
    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_n_q, be_n_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              wdoe_q, wdoe_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              busy_q, busy_d;

    // MEM wins when it is the only requester, or on contention if IF went last
    logic              grant_mem;
    assign grant_mem = bus.mem_req_i && (!bus.if_req_i || (last_q == PORT_IF));

    // State register plus every registered output; reset forces the idle pin state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gnt_q       <= PORT_IF;
            last_q      <= PORT_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_n_q      <= 4'hF;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            wdoe_q      <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_n_q      <= be_n_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            wdoe_q      <= wdoe_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Next state and the pin values that state will present (outputs are registered)
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_n_d      = 4'hF;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        wdoe_d      = 1'b0;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.if_req_i || bus.mem_req_i) begin
                    gnt_d = grant_mem ? PORT_MEM : PORT_IF;
                    if (grant_mem) begin
                        addr_d  = bus.mem_addr_i;
                        wdata_d = bus.mem_wdata_i;
                    end else begin
                        addr_d  = bus.if_addr_i;
                    end
                    if (grant_mem && bus.mem_we_i) begin
                        if (bus.mem_be_i != 4'b0000) begin
                            state_d = ST_WR_SETUP;
                            ce_n_d  = 1'b0;
                            wdoe_d  = 1'b1;
                            be_n_d  = ~bus.mem_be_i;
                        end else begin
                            // Nothing to write: acknowledge without touching the SRAM
                            state_d   = ST_DONE;
                            mem_ack_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_RD;
                        ce_n_d  = 1'b0;
                        oe_n_d  = 1'b0;
                        be_n_d  = 4'b0000;
                    end
                end
            end

            ST_RD: begin
                if (cnt_q == RD_LAST) begin
                    // Last read cycle: data has settled, capture it for the owner
                    state_d = ST_DONE;
                    if (gnt_q == PORT_MEM) begin
                        mem_rdata_d = bus.sram_rdata_i;
                        mem_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d  = bus.sram_rdata_i;
                        if_ack_d    = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    ce_n_d = 1'b0;
                    oe_n_d = 1'b0;
                    be_n_d = 4'b0000;
                end
            end

            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                cnt_d   = '0;
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                wdoe_d  = 1'b1;
                be_n_d  = be_n_q;
            end

            ST_WR_PULSE: begin
                ce_n_d = 1'b0;
                wdoe_d = 1'b1;
                be_n_d = be_n_q;
                if (cnt_q == WR_LAST) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    we_n_d = 1'b0;
                end
            end

            ST_WR_HOLD: begin
                state_d   = ST_DONE;
                mem_ack_d = 1'b1;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = gnt_q;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.if_rdata_o      = if_rdata_q;
    assign bus.if_ack_o        = if_ack_q;
    assign bus.mem_rdata_o     = mem_rdata_q;
    assign bus.mem_ack_o       = mem_ack_q;
    assign bus.sram_addr_o     = addr_q;
    assign bus.sram_wdata_o    = wdata_q;
    assign bus.sram_wdata_oe_o = wdoe_q;
    assign bus.sram_ce_n_o     = ce_n_q;
    assign bus.sram_oe_n_o     = oe_n_q;
    assign bus.sram_we_n_o     = we_n_q;
    assign bus.sram_be_n_o     = be_n_q;
    assign bus.busy_o          = busy_q;

endmodule
`default_nettype wire
